regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Write-side front end for the RV32I register file.
- Merges single-cycle ALU results and multi-cycle load responses into the register file's single write port (write enable, destination index, write data).
- Buffers load responses in a small FIFO, aligns and sign-extends load data, and suppresses all writes to x0.
- Output is registered and drives the register file write port directly.

Parameters:
- XLEN, 32, datapath width.
- DEPTH, 2, load FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle; always accepted, no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load response offered.
- ld_ready  out  1  FIFO can accept a load response.
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  raw aligned word from memory.
- ld_funct3  in  3  load type (LB/LH/LW/LBU/LHU encoding).
- ld_offset  in  2  byte address bits [1:0].
- rf_we  out  1  write enable to the register file.
- rf_rd  out  5  write destination index.
- rf_wdata  out  XLEN  write data.
- pending  out  1  FIFO non-empty.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - Reset is sampled on the rising edge of clk; no asynchronous path.
  - On reset: rf_we=0, rf_rd=0, rf_wdata=0, FIFO emptied, pending=0, ld_ready=1 on the cycle after reset.
  - Reset in the middle of operation discards all buffered loads and any in-flight output.
- Enqueue:
  - A load response is enqueued when ld_valid and ld_ready are both high.
  - The entry stores {rd, funct3, offset, data}.
  - ld_ready = not full. It stays low when full even if a pop occurs the same cycle (no same-cycle pass-through).
- Arbitration, evaluated each cycle:
  - If alu_valid and alu_rd≠0, select ALU.
  - Else if the FIFO is non-empty, pop the head and select it.
  - Else nothing.
  - An ALU write to x0 is dropped and does not block a FIFO pop that cycle.
  - A FIFO head with rd=0 is popped and discarded: no rf_we.
- Latency:
  - The selection is registered.
  - rf_we/rf_rd/rf_wdata are valid exactly one cycle after selection.
  - rf_we is a one-cycle pulse per write.
  - Minimum load-to-write latency is 1 cycle when the FIFO is empty and there is no ALU conflict.
- Load formatting, applied at pop:
  - Byte = data >> (8*offset).
  - 000 LB: sign-extend bits [7:0].
  - 001 LH: half selected by offset[1], sign-extend.
  - 010 LW: full word; offset ignored.
  - 100 LBU / 101 LHU: zero-extend.
  - Any other funct3 is treated as LW.
  - Misaligned LH (offset[0]=1) uses offset[1] only.
- FIFO:
  - Circular, with read/write pointers one bit wider than log2(DEPTH) for full/empty detection.
  - Pointers wrap modulo 2*DEPTH.
  - Simultaneous push and pop when non-empty and not full: count unchanged.
- Starvation: continuous alu_valid with nonzero rd starves loads indefinitely by design. The issue stage guarantees gaps.
- pending = FIFO count ≠ 0; registered, and reflects state after the current edge.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, adds the following ports:
  - fwd_rs1 in 5, fwd_rs2 in 5.
  - fwd_hit1 out 1, fwd_hit2 out 1.
  - fwd_data1 out XLEN, fwd_data2 out XLEN.
- fwd_hitN = rf_we && rf_rd==fwd_rsN && fwd_rsN≠0, combinational.
- fwd_dataN = rf_wdata when hit, else 0.
- This lets readers see a value being written this cycle.
- When not defined, these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: after reset high for 2 cycles, rf_we=0, pending=0, ld_ready=1.
- ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF → next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
- Load format:
  - LB with data 0x80FF7F01, offset=3 → rf_wdata=0xFFFFFF80.
  - LHU with offset=2 → 0x000080FF.
  - LH with offset=0 → 0x00007F01.
- Conflict: alu_valid(rd=3) and ld_valid(rd=4) in the same cycle → rd=3 written at T+1, rd=4 at T+2, pending high for exactly 1 cycle.
- Full FIFO: hold alu_valid with rd=1 while pushing 3 loads → ld_ready low after 2 accepted. Drop alu_valid → loads written in order, then ld_ready returns high.
- x0 suppression and mid-reset:
  - ALU rd=0 with a queued load → load written, no x0 write.
  - Assert reset with 2 loads queued → no rf_we afterwards, pending=0.

Source files
------------

// File: rtl/regfile_wb_if.sv
// regfile_wb_if: bundle of write-back front-end signals.
//   ALU side  : alu_valid, alu_rd, alu_data (no backpressure)
//   Load side : ld_valid/ld_ready handshake, ld_rd, ld_data, ld_funct3, ld_offset
//   RF side   : rf_we, rf_rd, rf_wdata (registered), pending (load FIFO non-empty)
// master = producer/observer side (issue, memory, bench); slave = the arbiter.
interface regfile_wb_if #(parameter int XLEN = 32);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_offset;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            pending;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_offset,
    input  ld_ready, rf_we, rf_rd, rf_wdata, pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_offset,
    output ld_ready, rf_we, rf_rd, rf_wdata, pending
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-side front end of the RV32I register file.
// Merges ALU results and buffered load responses onto the single RF write
// port. ALU wins each cycle; loads wait in a DEPTH-entry FIFO, are
// aligned/extended when popped, and writes to x0 are suppressed.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   wb     - regfile_wb_if.slave (ALU, load handshake, RF write port, pending)
// Optional: define WB_BYPASS_EN to add fwd_rs1/fwd_rs2 inputs and
//   fwd_hit1/2, fwd_data1/2 outputs exposing the write in progress.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  regfile_wb_if.slave       wb
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]        fwd_rs1,
  input  logic [4:0]        fwd_rs2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [XLEN-1:0]   fwd_data1,
  output logic [XLEN-1:0]   fwd_data2
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [1:0]      offset;
    logic [XLEN-1:0] data;
  } ld_entry_t;

  ld_entry_t       mem [DEPTH];
  logic [AW:0]     wptr, rptr, wptr_n, rptr_n;
  logic            empty, full, push, alu_sel, take_ld, pop, store;
  ld_entry_t       incoming, head;
  logic [XLEN-1:0] ld_fmt;

  function automatic logic [XLEN-1:0] fmt_load(ld_entry_t e);
    logic [XLEN-1:0] shifted;
    logic [15:0]     half;
    shifted = e.data >> {e.offset, 3'b000};
    // Halfword picks by offset[1] only, so misaligned LH still returns a half.
    half    = e.offset[1] ? e.data[31:16] : e.data[15:0];
    case (e.funct3)
      3'b000:  fmt_load = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  fmt_load = {{(XLEN-16){half[15]}}, half};
      3'b100:  fmt_load = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  fmt_load = {{(XLEN-16){1'b0}}, half};
      default: fmt_load = e.data;
    endcase
  endfunction

  assign empty       = (wptr == rptr);
  assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wb.ld_ready = ~full;
  assign push        = wb.ld_valid & ~full;
  assign alu_sel     = wb.alu_valid && (wb.alu_rd != 5'd0);
  assign incoming    = {wb.ld_rd, wb.ld_funct3, wb.ld_offset, wb.ld_data};

  // With an empty FIFO the arriving response acts as the head, giving the
  // one-cycle load-to-write path; it is never stored in that case.
  assign head    = empty ? incoming : mem[rptr[AW-1:0]];
  assign take_ld = ~alu_sel & (~empty | push);
  assign pop     = take_ld & ~empty;
  assign store   = push & ~(take_ld & empty);
  assign ld_fmt  = fmt_load(head);

  assign wptr_n = wptr + {{AW{1'b0}}, store};
  assign rptr_n = rptr + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      wb.pending  <= 1'b0;
      wb.rf_we    <= 1'b0;
      wb.rf_rd    <= 5'd0;
      wb.rf_wdata <= '0;
    end else begin
      wptr       <= wptr_n;
      rptr       <= rptr_n;
      wb.pending <= (wptr_n != rptr_n);
      if (alu_sel) begin
        wb.rf_we    <= 1'b1;
        wb.rf_rd    <= wb.alu_rd;
        wb.rf_wdata <= wb.alu_data;
      end else if (take_ld && head.rd != 5'd0) begin
        wb.rf_we    <= 1'b1;
        wb.rf_rd    <= head.rd;
        wb.rf_wdata <= ld_fmt;
      end else begin
        // Covers idle cycles, dropped x0 ALU results and discarded x0 loads.
        wb.rf_we    <= 1'b0;
        wb.rf_rd    <= 5'd0;
        wb.rf_wdata <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wptr[AW-1:0]] <= incoming;
  end

`ifdef WB_BYPASS_EN
  assign fwd_hit1  = wb.rf_we && (wb.rf_rd == fwd_rs1) && (fwd_rs1 != 5'd0);
  assign fwd_hit2  = wb.rf_we && (wb.rf_rd == fwd_rs2) && (fwd_rs2 != 5'd0);
  assign fwd_data1 = fwd_hit1 ? wb.rf_wdata : '0;
  assign fwd_data2 = fwd_hit2 ? wb.rf_wdata : '0;
`endif
endmodule
